// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared line geometry, request-FSM state type and line helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_BITS  = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } pf_state_t;

  // Callers narrow the result back to their own address width.
  function automatic logic [63:0] line_base(input logic [63:0] addr);
    return addr & ~64'(LINE_BYTES - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_prefetch_buf_if.sv
// ============================================================================
// Module   : fetch_prefetch_buf_if
// Purpose  : I-cache request/response, redirect, consume and window signals.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_prefetch_buf_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic                 ic_req;
  logic [ADDR_W-1:0]    ic_addr;
  logic                 ic_ready;
  logic                 ic_rvalid;
  logic [LINE_BITS-1:0] ic_rdata;
  logic                 redirect;
  logic [ADDR_W-1:0]    redirect_eip;
  logic                 fe_consume;
  logic [3:0]           fe_len;
  logic                 pf_valid;
  logic [ADDR_W-1:0]    pf_eip;
  logic [LINE_BITS-1:0] pf_instr;

  modport master (
    output ic_req, ic_addr, pf_valid, pf_eip, pf_instr,
    input  ic_ready, ic_rvalid, ic_rdata, redirect, redirect_eip, fe_consume, fe_len
  );

  modport slave (
    input  ic_req, ic_addr, pf_valid, pf_eip, pf_instr,
    output ic_ready, ic_rvalid, ic_rdata, redirect, redirect_eip, fe_consume, fe_len
  );

endinterface

`default_nettype wire

// File: rtl/fetch_byte_rotator.sv
// ============================================================================
// Module   : fetch_byte_rotator
// Purpose  : Selects the 16-byte window starting at byte i_off of {L1,L0}.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_byte_rotator
  import fetch_pkg::*;
(
  input  wire logic [2*LINE_BITS-1:0] i_lines,
  input  wire logic [3:0]             i_off,
  output logic      [LINE_BITS-1:0]   o_window
);

  assign o_window = LINE_BITS'(i_lines >> {i_off, 3'b000});

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch_buf.sv
// ============================================================================
// Module   : fetch_prefetch_buf
// Purpose  : Two-line instruction prefetch buffer feeding a byte-aligned window.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_prefetch_buf
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_EIP = '0
)(
  input  wire logic            clk,
  input  wire logic            reset_n,
  fetch_prefetch_buf_if.master bus
);

  pf_state_t            r_state;
  logic [LINE_BITS-1:0] r_l0, r_l1, w_l0_s, w_window;
  logic                 r_v0, r_v1, w_v0_s, w_v1_s;
  logic [ADDR_W-1:0]    r_eip, r_next_line, r_ic_addr, w_redir_line, w_req_line;
  logic                 r_ic_req;
  logic [3:0]           w_off;
  logic                 w_pf_valid, w_consume, w_cross, w_fill, w_fill_l0, w_fill_l1;

  assign w_off        = r_eip[3:0];
  assign w_pf_valid   = r_v0 & ((w_off == 4'd0) | r_v1);
  assign w_consume    = bus.fe_consume & w_pf_valid & (bus.fe_len != 4'd0) & ~bus.redirect;
  assign w_cross      = w_consume & (({1'b0, w_off} + {1'b0, bus.fe_len}) >= 5'd16);
  assign w_redir_line = ADDR_W'(line_base(64'(bus.redirect_eip)));
  assign w_req_line   = bus.redirect ? w_redir_line : r_next_line;

  // Slot state after this cycle's shift/redirect, before any fill lands.
  assign w_l0_s = w_cross ? r_l1 : r_l0;
  assign w_v0_s = bus.redirect ? 1'b0 : (w_cross ? r_v1 : r_v0);
  assign w_v1_s = bus.redirect ? 1'b0 : (w_cross ? 1'b0 : r_v1);

  assign w_fill    = (r_state == ST_WAIT) & bus.ic_rvalid & ~bus.redirect;
  assign w_fill_l0 = w_fill & ~w_v0_s;
  assign w_fill_l1 = w_fill & w_v0_s;

  fetch_byte_rotator u_rot (
    .i_lines  ({r_l1, r_l0}),
    .i_off    (w_off),
    .o_window (w_window)
  );

  assign bus.ic_req   = r_ic_req;
  assign bus.ic_addr  = r_ic_addr;
  assign bus.pf_valid = w_pf_valid;
  assign bus.pf_eip   = r_eip;
  assign bus.pf_instr = w_pf_valid ? w_window : '0;

  always_ff @(posedge clk) begin
    r_l0 <= w_fill_l0 ? bus.ic_rdata : w_l0_s;
    r_l1 <= w_fill_l1 ? bus.ic_rdata : r_l1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_v0        <= 1'b0;
      r_v1        <= 1'b0;
      r_eip       <= RESET_EIP;
      r_next_line <= ADDR_W'(line_base(64'(RESET_EIP)));
      r_ic_req    <= 1'b0;
      r_ic_addr   <= '0;
    end else begin
      r_v0 <= w_v0_s | w_fill_l0;
      r_v1 <= w_v1_s | w_fill_l1;

      if (bus.redirect) begin
        r_eip       <= bus.redirect_eip;
        r_next_line <= w_redir_line;
      end else if (w_consume) begin
        r_eip <= r_eip + ADDR_W'(bus.fe_len);
      end

      case (r_state)
        ST_IDLE: begin
          if (!w_v0_s || !w_v1_s) begin
            r_ic_req    <= 1'b1;
            r_ic_addr   <= w_req_line;
            r_next_line <= w_req_line + ADDR_W'(LINE_BYTES);
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A request accepted in the redirect cycle still owes a response.
          if (bus.redirect) begin
            r_ic_req <= 1'b0;
            r_state  <= bus.ic_ready ? ST_DROP : ST_IDLE;
          end else if (bus.ic_ready) begin
            r_ic_req <= 1'b0;
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.redirect) begin
            r_state <= bus.ic_rvalid ? ST_IDLE : ST_DROP;
          end else if (bus.ic_rvalid) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (bus.ic_rvalid) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefetch_buf.sv
// ============================================================================
// Module   : tb_fetch_prefetch_buf
// Purpose  : Directed self-checking bench with an inline one-line I-cache model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_prefetch_buf;

  logic        clk = 1'b0;
  logic        reset_n;
  int          checks = 0;
  int          errors = 0;
  logic        pend;
  logic [31:0] pend_addr;
  logic        resp_en;
  logic [127:0] w;

  always #5 clk = ~clk;

  fetch_prefetch_buf_if #(.ADDR_W(32)) bus ();

  fetch_prefetch_buf #(
    .ADDR_W    (32),
    .RESET_EIP (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  // Memory image: byte at address a holds a[7:0].
  function automatic logic [127:0] win(input logic [31:0] a);
    logic [127:0] r;
    logic [31:0]  t;
    for (int k = 0; k < 16; k++) begin
      t = a + 32'(k);
      r[8*k +: 8] = t[7:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: respond to the outstanding request, note acceptance, advance.
  task automatic tick();
    bus.ic_rvalid = 1'b0;
    bus.ic_rdata  = '0;
    if (pend && resp_en) begin
      bus.ic_rvalid = 1'b1;
      bus.ic_rdata  = win(pend_addr);
      pend = 1'b0;
    end
    if (bus.ic_req && bus.ic_ready) begin
      pend      = 1'b1;
      pend_addr = bus.ic_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, input string tag);
    int n = 0;
    while (!bus.pf_valid && n < max) begin
      tick();
      n++;
    end
    checks++;
    assert (bus.pf_valid === 1'b1) else begin
      errors++;
      $error("FAIL %s observed pf_valid=%b expected=1 within %0d cycles", tag, bus.pf_valid, max);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ic_req"},   128'(bus.ic_req),   128'h0);
    chk({tag, "_ic_addr"},  128'(bus.ic_addr),  128'h0);
    chk({tag, "_pf_valid"}, 128'(bus.pf_valid), 128'h0);
    chk({tag, "_pf_eip"},   128'(bus.pf_eip),   128'h0);
    chk({tag, "_pf_instr"}, bus.pf_instr,       128'h0);
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.ic_ready     = 1'b1;
    bus.ic_rvalid    = 1'b0;
    bus.ic_rdata     = '0;
    bus.redirect     = 1'b0;
    bus.redirect_eip = '0;
    bus.fe_consume   = 1'b0;
    bus.fe_len       = 4'd0;
    pend             = 1'b0;
    pend_addr        = '0;
    resp_en          = 1'b1;

    // 1: reset and first fills
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    reset_n = 1'b1;
    tick();
    chk("t1_req",   128'(bus.ic_req),  128'h1);
    chk("t1_addr0", 128'(bus.ic_addr), 128'h0);
    tick();
    tick();
    chk("t1_valid", 128'(bus.pf_valid), 128'h1);
    chk("t1_instr", bus.pf_instr, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    chk("t1_eip",   128'(bus.pf_eip), 128'h0);
    tick();
    chk("t1_addr1", 128'(bus.ic_addr), 128'h10);
    tick();
    tick();

    // 2: redirect to a line-crossing window
    bus.redirect     = 1'b1;
    bus.redirect_eip = 32'h1C;
    tick();
    bus.redirect = 1'b0;
    chk("t2_req_lat", 128'(bus.ic_req),   128'h1);
    chk("t2_addr",    128'(bus.ic_addr),  128'h10);
    chk("t2_nvalid0", 128'(bus.pf_valid), 128'h0);
    tick();
    tick();
    chk("t2_nvalid1", 128'(bus.pf_valid), 128'h0);
    tick();
    tick();
    tick();
    chk("t2_valid", 128'(bus.pf_valid), 128'h1);
    w = bus.pf_instr;
    chk("t2_b0",  128'(w[7:0]),     128'h1C);
    chk("t2_b3",  128'(w[31:24]),   128'h1F);
    chk("t2_b4",  128'(w[39:32]),   128'h20);
    chk("t2_b15", 128'(w[127:120]), 128'h2B);
    chk("t2_win", w, win(32'h1C));

    // 3: consume across the line boundary
    bus.fe_consume = 1'b1;
    bus.fe_len     = 4'd6;
    tick();
    bus.fe_consume = 1'b0;
    chk("t3_eip",   128'(bus.pf_eip),   128'h22);
    chk("t3_req",   128'(bus.ic_req),   128'h1);
    chk("t3_addr",  128'(bus.ic_addr),  128'h30);
    chk("t3_valid", 128'(bus.pf_valid), 128'h0);

    // 4: redirect while the 0x30 response is outstanding
    resp_en = 1'b0;
    tick();
    chk("t4_wait_req", 128'(bus.ic_req), 128'h0);
    bus.redirect     = 1'b1;
    bus.redirect_eip = 32'h100;
    tick();
    bus.redirect = 1'b0;
    chk("t4_eip",    128'(bus.pf_eip),   128'h100);
    chk("t4_valid0", 128'(bus.pf_valid), 128'h0);
    resp_en = 1'b1;
    tick();
    chk("t4_drop_valid", 128'(bus.pf_valid), 128'h0);
    chk("t4_drop_req",   128'(bus.ic_req),   128'h0);
    tick();
    chk("t4_req",  128'(bus.ic_req),  128'h1);
    chk("t4_addr", 128'(bus.ic_addr), 128'h100);
    tick();
    tick();
    chk("t4_valid1", 128'(bus.pf_valid), 128'h1);
    chk("t4_instr",  bus.pf_instr, win(32'h100));

    // 5: backpressure, redirect+consume, zero length
    bus.ic_ready = 1'b0;
    tick();
    chk("t5_req",  128'(bus.ic_req),  128'h1);
    chk("t5_addr", 128'(bus.ic_addr), 128'h110);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_req",  128'(bus.ic_req),  128'h1);
      chk("t5_hold_addr", 128'(bus.ic_addr), 128'h110);
    end
    bus.ic_ready = 1'b1;
    tick();
    tick();
    chk("t5_instr", bus.pf_instr, win(32'h100));
    bus.fe_consume   = 1'b1;
    bus.fe_len       = 4'd4;
    bus.redirect     = 1'b1;
    bus.redirect_eip = 32'h205;
    tick();
    bus.fe_consume = 1'b0;
    bus.redirect   = 1'b0;
    chk("t5_rc_eip",   128'(bus.pf_eip),   128'h205);
    chk("t5_rc_valid", 128'(bus.pf_valid), 128'h0);
    chk("t5_rc_addr",  128'(bus.ic_addr),  128'h200);
    wait_valid(10, "t5_refill");
    chk("t5_rc_instr", bus.pf_instr, win(32'h205));
    bus.fe_consume = 1'b1;
    bus.fe_len     = 4'd0;
    tick();
    chk("t5_len0_eip", 128'(bus.pf_eip), 128'h205);
    bus.fe_len = 4'd3;
    tick();
    bus.fe_consume = 1'b0;
    chk("t5_c3_eip",   128'(bus.pf_eip),   128'h208);
    chk("t5_c3_valid", 128'(bus.pf_valid), 128'h1);
    chk("t5_c3_instr", bus.pf_instr, win(32'h208));

    // 6: asynchronous reset in WAIT, late response ignored
    bus.fe_consume = 1'b1;
    bus.fe_len     = 4'd8;
    tick();
    bus.fe_consume = 1'b0;
    chk("t6_eip",   128'(bus.pf_eip),  128'h210);
    chk("t6_instr", bus.pf_instr,      win(32'h210));
    chk("t6_addr",  128'(bus.ic_addr), 128'h220);
    resp_en = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("t6_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    resp_en = 1'b1;
    tick();
    chk("t6_late_valid", 128'(bus.pf_valid), 128'h0);
    chk("t6_req",        128'(bus.ic_req),   128'h1);
    chk("t6_addr0",      128'(bus.ic_addr),  128'h0);
    tick();
    tick();
    chk("t6_valid", 128'(bus.pf_valid), 128'h1);
    chk("t6_win",   bus.pf_instr,       win(32'h0));
    chk("t6_peip",  128'(bus.pf_eip),   128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
